// File: rtl/lr35902_ppu_obj_scan.sv
// OAM search unit: scans OAM for objects on the current line, fills a
// priority-ordered buffer and serves X-match lookups to the pixel fetcher.
module lr35902_ppu_obj_scan #(
    parameter int unsigned MAX_OBJ     = 10,
    parameter int unsigned OAM_ENTRIES = 40,
    parameter logic [15:0] OAM_BASE    = 16'hfe00
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           clear,
    input  logic [7:0]                     ly,
    input  logic                           obj_size,
    output logic                           oam_read,
    output logic [15:0]                    oam_adr,
    input  logic [15:0]                    oam_data16,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MAX_OBJ+1)-1:0]   nobj,
    input  logic [7:0]                     px_x,
    output logic                           hit,
    output logic [7:0]                     hit_tile,
    output logic [7:0]                     hit_attr,
    output logic [2:0]                     hit_row,
    input  logic                           consume
);

    localparam int unsigned NW     = $clog2(MAX_OBJ + 1);
    localparam int unsigned SW     = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1;
    localparam int unsigned NWORDS = 2 * OAM_ENTRIES;
    localparam int unsigned CW     = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;

    logic [7:0]        ly_q;
    logic              size_q;
    logic              pend_acc;
    logic [7:0]        pend_x;
    logic [3:0]        pend_d;

    logic [MAX_OBJ-1:0] slot_valid;
    logic [7:0]         slot_x    [MAX_OBJ];
    logic [7:0]         slot_tile [MAX_OBJ];
    logic [7:0]         slot_attr [MAX_OBJ];
    logic [2:0]         slot_row  [MAX_OBJ];

    logic [SW-1:0]     hit_idx;
    logic [4:0]        h_c;
    logic [8:0]        d_c;
    logic              acc_c;
    logic              cap_c;
    logic              first_c;
    logic [3:0]        r_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; cnt counts SCAN cycles, one OAM word per cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                end
            end
            SCAN: begin
                if (start) begin
                    cnt_n = '0;
                end else if (cnt == CW'(NWORDS)) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                if (start) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
    end

    // Registered strobe, address and status outputs derived from next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oam_read <= 1'b0;
            oam_adr  <= OAM_BASE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            oam_read <= (state_n == SCAN) && (cnt_n < CW'(NWORDS));
            if ((state_n == SCAN) && (cnt_n < CW'(NWORDS))) begin
                oam_adr <= OAM_BASE + 16'({cnt_n, 1'b0});
            end
            busy <= (state_n == SCAN);
            done <= (state_n == DONE);
        end
    end

    // Y test in 9 bits so Y<16 and bottom-edge objects never wrap
    always_comb begin
        h_c     = size_q ? 5'd16 : 5'd8;
        d_c     = {1'b0, ly_q} + 9'd16 - {1'b0, oam_data16[7:0]};
        acc_c   = !d_c[8] && (d_c < {4'b0, h_c}) && (nobj < NW'(MAX_OBJ));
        cap_c   = (state == SCAN) && (cnt != '0) && !start && !clear;
        first_c = cnt[0];
        r_c     = oam_data16[14] ? (4'(h_c - 5'd1) - pend_d) : pend_d;
    end

    // Scan datapath: line parameters, pending first word, object count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ly_q     <= '0;
            size_q   <= 1'b0;
            pend_acc <= 1'b0;
            pend_x   <= '0;
            pend_d   <= '0;
            nobj     <= '0;
        end else if (clear) begin
            pend_acc <= 1'b0;
            nobj     <= '0;
        end else if (start) begin
            ly_q     <= ly;
            size_q   <= obj_size;
            pend_acc <= 1'b0;
            nobj     <= '0;
        end else if (cap_c) begin
            if (first_c) begin
                pend_acc <= acc_c;
                pend_x   <= oam_data16[15:8];
                pend_d   <= d_c[3:0];
            end else if (pend_acc) begin
                pend_acc <= 1'b0;
                nobj     <= nobj + NW'(1);
            end
        end
    end

    // Slot buffer: fill on accepted second word, invalidate on consume
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            for (int i = 0; i < int'(MAX_OBJ); i++) begin
                slot_x[i]    <= '0;
                slot_tile[i] <= '0;
                slot_attr[i] <= '0;
                slot_row[i]  <= '0;
            end
        end else if (clear || start) begin
            slot_valid <= '0;
        end else begin
            if (hit && consume) begin
                slot_valid[hit_idx] <= 1'b0;
            end
            if (cap_c && !first_c && pend_acc) begin
                slot_valid[SW'(nobj)] <= 1'b1;
                slot_x[SW'(nobj)]     <= pend_x;
                slot_tile[SW'(nobj)]  <= size_q ? {oam_data16[7:1], r_c[3]} : oam_data16[7:0];
                slot_attr[SW'(nobj)]  <= oam_data16[15:8];
                slot_row[SW'(nobj)]   <= r_c[2:0];
            end
        end
    end

    // Lookup: lowest-numbered valid slot matching px_x
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_tile = '0;
        hit_attr = '0;
        hit_row  = '0;
        for (int i = 0; i < int'(MAX_OBJ); i++) begin
            if (!hit && slot_valid[i] && (slot_x[i] == px_x)) begin
                hit      = 1'b1;
                hit_idx  = SW'(i);
                hit_tile = slot_tile[i];
                hit_attr = slot_attr[i];
                hit_row  = slot_row[i];
            end
        end
    end

endmodule

// File: tb/tb_lr35902_ppu_obj_scan.sv
// Self-checking bench for lr35902_ppu_obj_scan: OAM memory model,
// scan scoreboard and table-driven lookup/consume vectors.
module tb_lr35902_ppu_obj_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  ly = '0;
    logic        obj_size = 1'b0;
    logic        oam_read;
    logic [15:0] oam_adr;
    logic [15:0] oam_data16 = '0;
    logic        busy;
    logic        done;
    logic [3:0]  nobj;
    logic [7:0]  px_x = '0;
    logic        hit;
    logic [7:0]  hit_tile;
    logic [7:0]  hit_attr;
    logic [2:0]  hit_row;
    logic        consume = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] oam [160];

    typedef struct {
        int         nobj;
        int         lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         grp;
        logic [7:0] px;
        logic       cons;
        logic       eh;
        logic [7:0] et;
        logic [7:0] ea;
        logic [2:0] er;
    } vec_t;
    vec_t vecs[$];

    lr35902_ppu_obj_scan dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .ly         (ly),
        .obj_size   (obj_size),
        .oam_read   (oam_read),
        .oam_adr    (oam_adr),
        .oam_data16 (oam_data16),
        .busy       (busy),
        .done       (done),
        .nobj       (nobj),
        .px_x       (px_x),
        .hit        (hit),
        .hit_tile   (hit_tile),
        .hit_attr   (hit_attr),
        .hit_row    (hit_row),
        .consume    (consume)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // OAM memory: data for a strobe appears in the following cycle
    always @(posedge clk) begin
        if (oam_read) begin
            int a;
            a = int'(oam_adr - 16'hfe00);
            if (a >= 0 && a < 159) oam_data16 <= {oam[a+1], oam[a]};
            else oam_data16 <= 16'h0000;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 160; i++) oam[i] = 8'h00;
    endtask

    task automatic set_ent(input int k, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] tile, input logic [7:0] attr);
        oam[4*k]   = y;
        oam[4*k+1] = x;
        oam[4*k+2] = tile;
        oam[4*k+3] = attr;
    endtask

    task automatic addv(input int g, input logic [7:0] px, input logic cons, input logic eh,
                        input logic [7:0] et, input logic [7:0] ea, input logic [2:0] er);
        vec_t v;
        v.grp = g; v.px = px; v.cons = cons; v.eh = eh; v.et = et; v.ea = ea; v.er = er;
        vecs.push_back(v);
    endtask

    // Reference count of accepted objects for the current OAM image
    function automatic int model_nobj(input int l, input bit sz);
        int n;
        int h;
        int d;
        n = 0;
        h = sz ? 16 : 8;
        for (int k = 0; k < 40; k++) begin
            d = l + 16 - int'(oam[4*k]);
            if (d >= 0 && d < h && n < 10) n++;
        end
        return n;
    endfunction

    // Start a scan, check the strobe sweep, then pop and check the result
    task automatic run_scan(input logic [7:0] l, input logic sz, input string tag);
        exp_t e;
        exp_t got;
        int   c;
        int   n;
        int   j;
        int   bad;
        int   lat;
        bit   seen;
        e.nobj = model_nobj(int'(l), sz);
        e.lat  = 82;
        sb.push_back(e);
        @(negedge clk);
        ly = l; obj_size = sz; start = 1'b1;
        c = cyc;
        bad = 0; seen = 0; n = 0; lat = 0;
        while (!seen && n < 200) begin
            n++;
            @(negedge clk);
            start = 1'b0;
            j = cyc - c;
            if (done) begin
                seen = 1;
                lat = j;
            end else if (j <= 80) begin
                if (!(oam_read === 1'b1 && busy === 1'b1 &&
                      oam_adr === 16'hfe00 + 16'(2 * (j - 1)))) bad++;
            end else if (j == 81) begin
                if (!(oam_read === 1'b0 && busy === 1'b1)) bad++;
            end
        end
        check({tag, " strobe_seq_bad"}, bad, 0);
        got = sb.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout: no done within 200 cycles, required at %0d", tag, got.lat);
        end else begin
            check({tag, " done_latency"}, lat, got.lat);
            check({tag, " nobj"}, 32'(nobj), got.nobj);
            check({tag, " busy_at_done"}, 32'(busy), 0);
            @(negedge clk);
            check({tag, " done_pulse_len"}, 32'(done), 0);
        end
    endtask

    // Apply all lookup vectors of one group
    task automatic apply_group(input int g);
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                @(negedge clk);
                px_x = vecs[i].px;
                consume = vecs[i].cons;
                #1;
                check($sformatf("g%0d v%0d hit", g, i), 32'(hit), 32'(vecs[i].eh));
                if (vecs[i].eh) begin
                    check($sformatf("g%0d v%0d tile", g, i), 32'(hit_tile), 32'(vecs[i].et));
                    check($sformatf("g%0d v%0d attr", g, i), 32'(hit_attr), 32'(vecs[i].ea));
                    check($sformatf("g%0d v%0d row", g, i), 32'(hit_row), 32'(vecs[i].er));
                end
            end
        end
        @(negedge clk);
        consume = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  saw;

        // group 1: single object at entry 3
        addv(1, 8'd30, 1'b0, 1'b1, 8'h42, 8'h00, 3'd6);
        addv(1, 8'd31, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        addv(1, 8'd29, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        // group 2: Y=0 rejected, Y=16 accepted at ly=0
        addv(2, 8'd5,  1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        addv(2, 8'd6,  1'b0, 1'b1, 8'h11, 8'h00, 3'd0);
        // groups 3/4: 8x16 with and without Y-flip
        addv(3, 8'd20, 1'b0, 1'b1, 8'h42, 8'h40, 3'd3);
        addv(4, 8'd20, 1'b0, 1'b1, 8'h43, 8'h00, 3'd0);
        // group 5: buffer full, entries 0..9 only
        addv(5, 8'd10, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);
        addv(5, 8'd19, 1'b0, 1'b1, 8'h09, 8'h00, 3'd0);
        addv(5, 8'd20, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        addv(5, 8'd49, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        // group 6: three objects at X=50 consumed in OAM order
        addv(6, 8'd60, 1'b0, 1'b1, 8'h03, 8'h20, 3'd6);
        addv(6, 8'd50, 1'b1, 1'b1, 8'h02, 8'h00, 3'd6);
        addv(6, 8'd50, 1'b1, 1'b1, 8'h05, 8'h00, 3'd6);
        addv(6, 8'd50, 1'b1, 1'b1, 8'h07, 8'h00, 3'd6);
        addv(6, 8'd50, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        addv(6, 8'd60, 1'b0, 1'b1, 8'h03, 8'h20, 3'd6);

        clear_oam();
        repeat (3) @(negedge clk);
        #1;
        check("rst oam_read", 32'(oam_read), 0);
        check("rst oam_adr", 32'(oam_adr), 32'h fe00);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst nobj", 32'(nobj), 0);
        check("rst hit", 32'(hit), 0);
        check("rst hit_tile", 32'(hit_tile), 0);
        check("rst hit_row", 32'(hit_row), 0);
        @(negedge clk);
        reset = 1'b0;

        clear_oam();
        set_ent(3, 8'd20, 8'd30, 8'h42, 8'h00);
        run_scan(8'd10, 1'b0, "A");
        apply_group(1);

        clear_oam();
        set_ent(0, 8'd0,  8'd5, 8'h10, 8'h00);
        set_ent(1, 8'd16, 8'd6, 8'h11, 8'h00);
        run_scan(8'd0, 1'b0, "B");
        apply_group(2);

        clear_oam();
        set_ent(0, 8'd16, 8'd20, 8'h43, 8'h40);
        run_scan(8'd12, 1'b1, "C1");
        apply_group(3);

        set_ent(0, 8'd16, 8'd20, 8'h43, 8'h00);
        run_scan(8'd8, 1'b1, "C2");
        apply_group(4);

        clear_oam();
        for (int k = 0; k < 40; k++) set_ent(k, 8'd16, 8'(10 + k), 8'(k), 8'h00);
        run_scan(8'd0, 1'b0, "D");
        apply_group(5);

        clear_oam();
        set_ent(2, 8'd20, 8'd50, 8'h02, 8'h00);
        set_ent(3, 8'd20, 8'd60, 8'h03, 8'h20);
        set_ent(5, 8'd20, 8'd50, 8'h05, 8'h00);
        set_ent(7, 8'd20, 8'd50, 8'h07, 8'h00);
        run_scan(8'd10, 1'b0, "E");
        apply_group(6);

        // Asynchronous reset in the middle of a full scan
        clear_oam();
        for (int k = 0; k < 40; k++) set_ent(k, 8'd16, 8'(10 + k), 8'(k), 8'h00);
        @(negedge clk);
        ly = 8'd0; obj_size = 1'b0; start = 1'b1; px_x = 8'd10;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        while ((cyc - c) < 40) @(negedge clk);
        check("mid nobj_before_reset", 32'(nobj), 10);
        #2 reset = 1'b1;
        #1;
        check("mid busy", 32'(busy), 0);
        check("mid nobj", 32'(nobj), 0);
        check("mid oam_read", 32'(oam_read), 0);
        check("mid hit", 32'(hit), 0);
        @(negedge clk);
        reset = 1'b0;
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) saw = 1;
        end
        check("mid no_done_after_reset", 32'(saw), 0);
        run_scan(8'd0, 1'b0, "R");

        // clear and start together: clear wins, buffer emptied
        @(negedge clk);
        px_x = 8'd10;
        #1;
        check("cs hit_before", 32'(hit), 1);
        @(negedge clk);
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("cs busy", 32'(busy), 0);
        check("cs oam_read", 32'(oam_read), 0);
        check("cs hit_after", 32'(hit), 0);
        check("cs nobj", 32'(nobj), 0);
        saw = 0;
        repeat (90) begin
            @(negedge clk);
            if (done || busy || oam_read) saw = 1;
        end
        check("cs stays_idle", 32'(saw), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lr35902_ppu_obj_scan.md
# lr35902_ppu_obj_scan

Parametrised OAM search unit for the LR35902 PPU. It is a successor to the in-line mode-2 object scan. On each line it walks OAM over a 16-bit read port and fills a buffer of up to MAX_OBJ visible objects. It precomputes the row within each object, handling Y-flip and 8x16 tile selection. It then serves X-coordinate match lookups and consume requests to the pixel-transfer fetcher. The Y test uses 9-bit arithmetic, so objects with Y < 16 or near the bottom edge never alias through 8-bit wrap.

## Interface
- MAX_OBJ, 10: buffer slots; maximum objects accepted per line.
- OAM_ENTRIES, 40: number of 4-byte OAM entries scanned.
- OAM_BASE, 16'hfe00: byte address of OAM entry 0.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; begins a scan for line `ly`; also clears the buffer.
- clear  in  1  one-cycle pulse; invalidates all slots and returns to IDLE (end of line / PPU off).
- ly  in  8  current line, sampled on `start`.
- obj_size  in  1  0: 8x8, 1: 8x16; sampled on `start`.
- oam_read  out  1  read strobe.
- oam_adr  out  16  OAM byte address (always even).
- oam_data16  in  16  read data, valid the cycle after the strobe; {byte adr+1, byte adr}.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan completes.
- nobj  out  clog2(MAX_OBJ+1)  number of objects accepted.
- px_x  in  8  X coordinate queried by the fetcher (OAM X units).
- hit  out  1  a valid slot has X == px_x.
- hit_tile  out  8  tile number of the hit slot, with the 8x16 low bit already applied.
- hit_attr  out  8  attribute byte of the hit slot.
- hit_row  out  3  row within the 8-pixel tile, flip-corrected.
- consume  in  1  invalidate the current hit slot at the next edge; ignored when hit=0.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on `start`.
  - SCAN -> DONE after the last entry's second word is captured.
  - DONE -> IDLE on the next cycle (`done` pulses there).
  - Any state -> IDLE on `clear`.
  - `start` while in SCAN restarts the scan from entry 0 with an empty buffer.
- Scan order per entry k:
  - Even cycle: read OAM_BASE+4k, giving {X, Y}.
  - Odd cycle: read OAM_BASE+4k+2, giving {attr, tile}.
- Y test on the {X,Y} data, with h = 16 if obj_size else 8:
  - Compute d = {1'b0,ly} + 16 - {1'b0,Y} in 9 bits, signed.
  - The entry is accepted when 0 <= d < h and nobj < MAX_OBJ.
  - Accepted X is latched pending the second word.
- Second word of an accepted entry fills slot nobj, then nobj increments:
  - r = attr[6] ? h-1-d : d.
  - tile = obj_size ? {tile[7:1], r[3]} : tile.
  - row = r[2:0].
  - valid = 1.
- Once nobj == MAX_OBJ, remaining entries are still read (fixed scan length) but none are accepted.
- Lookup is combinational: `hit` selects the lowest-numbered valid slot with X == px_x. Slot order equals OAM order, so ties resolve to the lowest OAM index.
- `consume` with hit=1 clears that slot's valid bit. The next-priority slot at the same X then becomes the hit in the following cycle.
- Lookups and consumes are legal in any state. During SCAN they see only slots already filled.
- `start` and `clear` in the same cycle: `clear` wins.

## Timing
- Reset values:
  - oam_read=0, oam_adr=OAM_BASE, busy=0, done=0, nobj=0.
  - All slots invalid, so hit=0 and hit_tile/attr/row=0.
- `start` at cycle T:
  - Cycle T+1: first strobe, oam_adr=OAM_BASE.
  - Strobes are continuous through T+2*OAM_ENTRIES, adr += 2 per cycle.
  - Data for the strobe at cycle n is consumed at n+1.
  - `done` pulses at T+2*OAM_ENTRIES+2 (T+82 at default).
  - `busy` is high T+1..T+2*OAM_ENTRIES+1.
- `nobj` and slot contents update the cycle after the second-word data is presented.
- `hit` and its fields are combinational from px_x and slot state. The `consume` effect is visible one cycle later.
- `reset` asserted mid-scan: outputs return to reset values asynchronously. No `done` is issued for the aborted scan.

## Test plan
- Single object at entry 3 (Y=20, X=30, tile=0x42, attr=0x00), ly=10, 8x8, start at T -> done at T+82, nobj=1; px_x=30 gives hit=1, tile=0x42, row=6.
- Entry 0 with Y=0 and ly=0 -> not accepted (d=16 >= 8). Entry 1 with Y=16, ly=0 -> accepted, row=0. Confirms no 8-bit wrap.
- 8x16 mode, Y=16, ly=12, tile=0x43, attr[6]=1 -> r=3, tile=0x42, row=3. Same with attr[6]=0 and ly=8 -> r=8, tile=0x43, row=0.
- All 40 entries visible at ly=0 -> nobj=10; slots hold entries 0..9; entry 10's X gives hit=0 if unique.
- Three objects at X=50 (entries 2, 5, 7): hit returns entry 2, then consume returns entry 5, consume returns entry 7, consume gives hit=0.
- Reset asserted at T+40 mid-scan -> busy=0, nobj=0, no done. A restart with `start` 5 cycles later completes normally. A `clear`+`start` in the same cycle leaves FSM in IDLE.
